// File: rtl/fp_mant_normalizer.sv
// Mantissa normalizer for the FP adder: carry, zero, special, overflow and underflow handling.
// Build option NORM_LZC_EN: resolve normalization in one cycle with a leading-zero count.
module fp_mant_normalizer #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] in_mant,
   input  logic              in_cout,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic              in_sign,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] out_mant,
   output logic [EXP_W-1:0]  out_exp,
   output logic              out_sign,
   output logic              out_zero,
   output logic              out_ovf,
   output logic              out_unf
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

   state_t            state_q, state_d;
   logic [MANT_W-1:0] mant_q, mant_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic              cout_q, cout_d;
   logic              sign_q, sign_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [EXP_W-1:0]  exp_inc;

   assign exp_inc = exp_q + 1'b1;

`ifdef NORM_LZC_EN
   function automatic logic [EXP_W-1:0] lead_zeros(input logic [MANT_W-1:0] m);
      logic [EXP_W-1:0] cnt;
      cnt = EXP_W'(MANT_W);
      for (int i = 0; i < MANT_W; i++)
         if (m[i]) cnt = EXP_W'(MANT_W - 1 - i);
      return cnt;
   endfunction

   logic [EXP_W-1:0] lz;
   assign lz = lead_zeros(mant_q);
`endif

   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      cout_d  = cout_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mant_d  = in_mant;
               cout_d  = in_cout;
               exp_d   = in_exp;
               sign_d  = in_sign;
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = NORM;
            end
         end
         NORM: begin
            if (cout_q) begin
               cout_d  = 1'b0;
               state_d = DONE;
               if (exp_inc == EXP_MAX) begin
                  mant_d = '0;
                  exp_d  = EXP_MAX;
                  ovf_d  = 1'b1;
               end else begin
                  mant_d = {1'b1, mant_q[MANT_W-1:1]};
                  exp_d  = exp_inc;
               end
            end else if (exp_q == EXP_MAX) begin
               // Inf/NaN operand: leave the payload untouched
               state_d = DONE;
            end else if (mant_q == '0) begin
               mant_d  = '0;
               exp_d   = '0;
               sign_d  = 1'b0;
               zero_d  = 1'b1;
               state_d = DONE;
            end else if (mant_q[MANT_W-1]) begin
               state_d = DONE;
`ifdef NORM_LZC_EN
            end else if (lz >= exp_q) begin
               mant_d  = '0;
               exp_d   = '0;
               zero_d  = 1'b1;
               unf_d   = 1'b1;
               state_d = DONE;
            end else begin
               mant_d  = mant_q << lz;
               exp_d   = exp_q - lz;
               state_d = DONE;
            end
`else
            end else if (exp_q <= EXP_ONE) begin
               mant_d  = '0;
               exp_d   = '0;
               zero_d  = 1'b1;
               unf_d   = 1'b1;
               state_d = DONE;
            end else begin
               mant_d  = mant_q << 1;
               exp_d   = exp_q - EXP_ONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mant_q  <= '0;
         exp_q   <= '0;
         cout_q  <= 1'b0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         cout_q  <= cout_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_mant  = mant_q;
   assign out_exp   = exp_q;
   assign out_sign  = sign_q;
   assign out_zero  = zero_q;
   assign out_ovf   = ovf_q;
   assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Scoreboard bench for fp_mant_normalizer: directed cases, random beats, backpressure and reset abort.
module tb_fp_mant_normalizer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_mant = '0;
   logic        in_cout = 1'b0;
   logic [7:0]  in_exp = '0;
   logic        in_sign = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_mant;
   logic [7:0]  out_exp;
   logic        out_sign, out_zero, out_ovf, out_unf;

   fp_mant_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mant(in_mant), .in_cout(in_cout), .in_exp(in_exp), .in_sign(in_sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
      .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [23:0] m;
      logic [7:0]  e;
      logic        s, z, o, u;
      int          lat;
      int          acc;
   } res_t;

   res_t sb[$];
   res_t snap;
   bit   seen = 0;
   bit   hold = 0;
   int   tests = 0;
   int   fails = 0;

   // Reference: normalize by counting leading zeros directly.
   function automatic res_t model(logic [23:0] m, logic c, logic [7:0] e, logic s);
      res_t r;
      int   msb, lz;
      r.m = m; r.e = e; r.s = s; r.z = 0; r.o = 0; r.u = 0; r.lat = 1; r.acc = 0;
      if (c) begin
         if (e == 8'd254) begin
            r.m = 0; r.e = 8'd255; r.o = 1;
         end else begin
            r.m = 24'((m >> 1) + 24'h800000);
            r.e = e + 8'd1;
         end
      end else if (e == 8'd255) begin
         r.m = m;
      end else if (m == 0) begin
         r.m = 0; r.e = 0; r.s = 0; r.z = 1;
      end else begin
         msb = 0;
         for (int i = 0; i < 24; i++) if (m[i]) msb = i;
         lz = 23 - msb;
         if (lz > 0) begin
            if (lz >= int'(e)) begin
               r.m = 0; r.e = 0; r.z = 1; r.u = 1;
               r.lat = (e == 0) ? 1 : int'(e);
            end else begin
               r.m = m << lz;
               r.e = e - 8'(lz);
               r.lat = lz + 1;
            end
         end
      end
`ifdef NORM_LZC_EN
      r.lat = 1;
`endif
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops on the first cycle of each result, then checks it stays put until taken.
   always @(negedge clk) begin
      if (rst) begin
         seen = 0;
      end else if (out_valid) begin
         tests++;
         if (in_ready) begin
            fails++;
            $display("FAIL in_ready_in_done got=%b required=0", in_ready);
         end
         if (!seen) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output mant=%h exp=%0d", out_mant, out_exp);
            end else begin
               snap = sb.pop_front();
               if (out_mant !== snap.m || out_exp !== snap.e || out_sign !== snap.s ||
                   out_zero !== snap.z || out_ovf !== snap.o || out_unf !== snap.u) begin
                  fails++;
                  $display("FAIL result got mant=%h exp=%0d s=%b z=%b o=%b u=%b required mant=%h exp=%0d s=%b z=%b o=%b u=%b",
                           out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf,
                           snap.m, snap.e, snap.s, snap.z, snap.o, snap.u);
               end
               tests++;
               if (cyc - snap.acc != snap.lat) begin
                  fails++;
                  $display("FAIL latency got=%0d required=%0d", cyc - snap.acc, snap.lat);
               end
            end
            seen = 1;
         end else begin
            tests++;
            if (out_mant !== snap.m || out_exp !== snap.e || out_sign !== snap.s ||
                out_zero !== snap.z || out_ovf !== snap.o || out_unf !== snap.u) begin
               fails++;
               $display("FAIL hold_stable got mant=%h exp=%0d required mant=%h exp=%0d",
                        out_mant, out_exp, snap.m, snap.e);
            end
         end
         if (out_ready) seen = 0;
      end
   end

   task automatic send(input logic [23:0] m, input logic c, input logic [7:0] e,
                       input logic s, input bit push);
      int   w = 0;
      res_t r;
      @(negedge clk);
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
         return;
      end
      in_mant = m; in_cout = c; in_exp = e; in_sign = s; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) begin
         r = model(m, c, e, s);
         r.acc = cyc;
         sb.push_back(r);
      end
   endtask

   task automatic drain();
      int w = 0;
      while ((sb.size() != 0 || !in_ready || out_valid) && w < 5000) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (sb.size() != 0 || !in_ready) begin
         fails++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      end
   endtask

   task automatic check_idle_zero(input string tag);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mant !== '0 || out_exp !== '0 ||
          out_sign !== 1'b0 || out_zero !== 1'b0 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
         fails++;
         $display("FAIL %s got rdy=%b vld=%b mant=%h exp=%0d s=%b z=%b o=%b u=%b required rdy=1 vld=0 all 0",
                  tag, in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf);
      end
   endtask

   initial begin
      logic [23:0] m;
      logic [7:0]  e;
      logic        c;
      int          w;

      repeat (3) @(negedge clk);
      check_idle_zero("reset_state");
      @(posedge clk); #1; rst = 1'b0;

      send(24'h00003E, 1'b0, 8'd130, 1'b0, 1);
      send(24'h000000, 1'b1, 8'd127, 1'b0, 1);
      send(24'h000000, 1'b0, 8'd140, 1'b1, 1);
      send(24'h000002, 1'b1, 8'd254, 1'b0, 1);
      send(24'h000001, 1'b0, 8'd5,   1'b1, 1);
      send(24'h812345, 1'b0, 8'd0,   1'b1, 1);
      send(24'h000F00, 1'b0, 8'd255, 1'b0, 1);
      send(24'h400000, 1'b0, 8'd2,   1'b0, 1);
      send(24'h400000, 1'b0, 8'd1,   1'b1, 1);
      send(24'hFFFFFF, 1'b1, 8'd253, 1'b1, 1);

      for (int i = 0; i < 150; i++) begin
         c = ($urandom_range(0, 4) == 0);
         m = 24'($urandom()) >> $urandom_range(0, 24);
         case ($urandom_range(0, 9))
            0:       e = 8'($urandom_range(0, 4));
            1:       e = 8'd255;
            2:       e = 8'd254;
            default: e = 8'($urandom_range(0, 254));
         endcase
         if (c && e == 8'd255) e = 8'd254;
         send(m, c, e, 1'($urandom_range(0, 1)), 1);
      end
      drain();

      // Backpressure: hold out_ready low for three cycles in DONE.
      hold = 1;
      send(24'h0001A5, 1'b0, 8'd100, 1'b1, 1);
      w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (!out_valid) begin
         fails++;
         $display("FAIL hold_wait out_valid=%b required=1", out_valid);
      end
      repeat (3) @(negedge clk);
      hold = 0;
      drain();

      // Reset while a beat is being normalized.
      send(24'h000003, 1'b0, 8'd200, 1'b1, 0);
      rst = 1'b1;
      #1;
      check_idle_zero("rst_abort");
      repeat (2) @(negedge clk);
      check_idle_zero("rst_held");
      @(posedge clk); #1; rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_emit out_valid=%b required=0", out_valid);
         end
      end
      check_idle_zero("after_rst");

      send(24'h000400, 1'b0, 8'd50, 1'b0, 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
